// File: rtl/median_frame_ctrl_if.sv
// AXI4-Stream pixel channel feeding the median frame controller.
// The master drives the beat; the slave returns tready.
interface median_frame_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tuser;
  logic                  tlast;
  logic                  tready;

  modport master (output tdata, tvalid, tuser, tlast, input tready);
  modport slave  (input tdata, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/median_frame_ctrl.sv
// Frame sequencer ahead of the 3x3 median pipeline: SOF lock, line/row framing checks, 1-cycle pixel forward.
// tready is decoded from the state register only and is low in IDLE and the single DONE gap cycle.
module median_frame_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 1280,
  parameter int IMG_HEIGHT = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic                  i_clear_err,
  median_frame_ctrl_if.slave    s_axis,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_data_valid,
  output logic                  o_start_of_frame,
  output logic                  o_busy,
  output logic                  o_frame_done,
  output logic [15:0]           o_frame_count,
  output logic                  o_err_early_eol,
  output logic                  o_err_late_eol,
  output logic                  o_err_sof_mid
);
  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, WAIT_SOF, ACTIVE, DONE} state_t;

  state_t                r_state;
  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_row;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_data_valid;
  logic                  r_sof;
  logic                  r_busy;
  logic                  r_frame_done;
  logic [15:0]           r_frame_count;
  logic                  r_err_early_eol;
  logic                  r_err_late_eol;
  logic                  r_err_sof_mid;

  logic w_tready;
  logic w_accept;
  logic w_eol;

  assign w_tready      = (r_state == WAIT_SOF) || (r_state == ACTIVE);
  assign s_axis.tready = w_tready;
  assign w_accept      = s_axis.tvalid & w_tready;
  // A line closes either at the last column or on an early tlast (resync).
  assign w_eol         = (r_col == COL_LAST) || s_axis.tlast;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state         <= IDLE;
      r_col           <= '0;
      r_row           <= '0;
      r_data          <= '0;
      r_data_valid    <= 1'b0;
      r_sof           <= 1'b0;
      r_busy          <= 1'b0;
      r_frame_done    <= 1'b0;
      r_frame_count   <= '0;
      r_err_early_eol <= 1'b0;
      r_err_late_eol  <= 1'b0;
      r_err_sof_mid   <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      r_sof        <= 1'b0;
      r_frame_done <= 1'b0;
      // Clear first so a same-cycle set event below wins.
      if (i_clear_err) begin
        r_err_early_eol <= 1'b0;
        r_err_late_eol  <= 1'b0;
        r_err_sof_mid   <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (i_enable) r_state <= WAIT_SOF;
        end
        WAIT_SOF: begin
          if (!i_enable) begin
            r_state <= IDLE;
          end else if (w_accept && s_axis.tuser) begin
            r_data       <= s_axis.tdata;
            r_data_valid <= 1'b1;
            r_sof        <= 1'b1;
            r_col        <= CW'(1);
            r_row        <= '0;
            r_state      <= ACTIVE;
            r_busy       <= 1'b1;
          end
        end
        ACTIVE: begin
          if (w_accept) begin
            r_data       <= s_axis.tdata;
            r_data_valid <= 1'b1;
            if (s_axis.tuser) begin
              r_err_sof_mid <= 1'b1;
              r_sof         <= 1'b1;
              r_col         <= CW'(1);
              r_row         <= '0;
            end else begin
              if ((r_col == COL_LAST) && !s_axis.tlast) r_err_late_eol  <= 1'b1;
              if ((r_col != COL_LAST) &&  s_axis.tlast) r_err_early_eol <= 1'b1;
              if (w_eol) begin
                r_col <= '0;
                if (r_row == ROW_LAST) begin
                  r_row         <= '0;
                  r_state       <= DONE;
                  r_busy        <= 1'b0;
                  r_frame_done  <= 1'b1;
                  r_frame_count <= r_frame_count + 16'd1;
                end else begin
                  r_row <= r_row + RW'(1);
                end
              end else begin
                r_col <= r_col + CW'(1);
              end
            end
          end
        end
        DONE: begin
          r_state <= i_enable ? WAIT_SOF : IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_data           = r_data;
  assign o_data_valid     = r_data_valid;
  assign o_start_of_frame = r_sof;
  assign o_busy           = r_busy;
  assign o_frame_done     = r_frame_done;
  assign o_frame_count    = r_frame_count;
  assign o_err_early_eol  = r_err_early_eol;
  assign o_err_late_eol   = r_err_late_eol;
  assign o_err_sof_mid    = r_err_sof_mid;
endmodule

// File: tb/tb_median_frame_ctrl.sv
// Directed bench for median_frame_ctrl on a 4x3 image with a cycle-level reference model and literal checks.
module tb_median_frame_ctrl;
  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int M_IDLE = 0, M_HUNT = 1, M_FRAME = 2, M_GAP = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] o_data;
  logic          o_data_valid, o_sof, o_busy, o_done;
  logic [15:0]   o_count;
  logic          o_ee, o_el, o_em;

  median_frame_ctrl_if #(.DATA_WIDTH(DW)) axis_if ();

  median_frame_ctrl #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .i_clk(clk), .i_reset(rst), .i_enable(en), .i_clear_err(clr),
    .s_axis(axis_if),
    .o_data(o_data), .o_data_valid(o_data_valid), .o_start_of_frame(o_sof),
    .o_busy(o_busy), .o_frame_done(o_done), .o_frame_count(o_count),
    .o_err_early_eol(o_ee), .o_err_late_eol(o_el), .o_err_sof_mid(o_em)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;
  bit g_gaps = 0;
  int n_vld = 0, n_sof = 0, n_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: position within the frame tracked as plain integers.
  int          m_mode, m_col, m_row, m_cnt;
  logic [DW-1:0] m_data;
  bit          m_vld, m_sof, m_done, m_ee, m_el, m_em;

  always @(posedge clk) begin : model
    bit acc, eol;
    if (rst) begin
      m_mode = M_IDLE; m_col = 0; m_row = 0; m_cnt = 0; m_data = '0;
      m_vld = 0; m_sof = 0; m_done = 0; m_ee = 0; m_el = 0; m_em = 0;
    end else begin
      acc = axis_if.tvalid && (m_mode == M_HUNT || m_mode == M_FRAME);
      m_vld = 0; m_sof = 0; m_done = 0;
      if (clr) begin m_ee = 0; m_el = 0; m_em = 0; end
      case (m_mode)
        M_IDLE: if (en) m_mode = M_HUNT;
        M_HUNT: begin
          if (!en) m_mode = M_IDLE;
          else if (acc && axis_if.tuser) begin
            m_vld = 1; m_sof = 1; m_data = axis_if.tdata;
            m_col = 1; m_row = 0; m_mode = M_FRAME;
          end
        end
        M_FRAME: if (acc) begin
          m_vld = 1; m_data = axis_if.tdata;
          if (axis_if.tuser) begin
            m_em = 1; m_sof = 1; m_col = 1; m_row = 0;
          end else begin
            eol = axis_if.tlast || (m_col == W - 1);
            if (m_col == W - 1 && !axis_if.tlast) m_el = 1;
            if (m_col <  W - 1 &&  axis_if.tlast) m_ee = 1;
            if (eol) begin
              m_col = 0;
              m_row++;
              if (m_row == H) begin
                m_row = 0; m_mode = M_GAP; m_done = 1; m_cnt = (m_cnt + 1) % 65536;
              end
            end else begin
              m_col++;
            end
          end
        end
        default: m_mode = en ? M_HUNT : M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("tready",       axis_if.tready, (m_mode == M_HUNT || m_mode == M_FRAME));
      check("data_valid",   o_data_valid,   m_vld);
      check("data",         o_data,         m_data);
      check("sof",          o_sof,          m_sof);
      check("busy",         o_busy,         (m_mode == M_FRAME));
      check("frame_done",   o_done,         m_done);
      check("frame_count",  o_count,        m_cnt[15:0]);
      check("err_early",    o_ee,           m_ee);
      check("err_late",     o_el,           m_el);
      check("err_sof_mid",  o_em,           m_em);
      n_vld  += int'(o_data_valid);
      n_sof  += int'(o_sof);
      n_done += int'(o_done);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1; en = 0; clr = 0;
    axis_if.tvalid = 0; axis_if.tuser = 0; axis_if.tlast = 0; axis_if.tdata = '0;
    tick();
    chk_en = 1;
    check("rst_tready", axis_if.tready, 0);
    check("rst_valid",  o_data_valid,   0);
    check("rst_data",   o_data,         0);
    check("rst_busy",   o_busy,         0);
    check("rst_count",  o_count,        0);
    check("rst_errs",   {o_ee, o_el, o_em}, 0);
    tick();
    rst = 0;
    n_vld = 0; n_sof = 0; n_done = 0;
  endtask

  task automatic beat(input logic [DW-1:0] d, input bit u, input bit l, input bit c);
    bit r;
    int n;
    if (g_gaps) repeat ($urandom_range(0, 2)) tick();
    axis_if.tdata = d; axis_if.tvalid = 1; axis_if.tuser = u; axis_if.tlast = l; clr = c;
    n = 0;
    do begin
      @(negedge clk); r = axis_if.tready;
      tick();
      n++;
    end while (!r && n < 64);
    check("beat_accepted", r, 1);
    axis_if.tvalid = 0; axis_if.tuser = 0; axis_if.tlast = 0; clr = 0;
  endtask

  task automatic send_lines(input logic [DW-1:0] base, input int l0, input int l1, input int l2,
                            input logic [2:0] lm, input int clr_beat);
    int lens[3];
    int k;
    lens[0] = l0; lens[1] = l1; lens[2] = l2;
    k = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < lens[r]; c++) begin
        beat(base + DW'(k), (k == 0), (c == lens[r] - 1) && lm[r], (k == clr_beat));
        k++;
      end
  endtask

  task automatic expect_done(input string name);
    @(negedge clk);
    check({name, "_done"},   o_done,         1);
    check({name, "_tready"}, axis_if.tready, 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    axis_if.tvalid = 0; axis_if.tuser = 0; axis_if.tlast = 0; axis_if.tdata = '0;

    // 1: junk before SOF is dropped, then one clean frame
    do_reset(); en = 1;
    for (int i = 0; i < 3; i++) beat(8'hA0 + DW'(i), 0, 0, 0);
    send_lines(8'h10, 4, 4, 4, 3'b111, -1);
    expect_done("t1");
    tick();
    @(negedge clk); check("t1_tready_back", axis_if.tready, 1);
    tick();
    check("t1_nvld", n_vld, 12); check("t1_nsof", n_sof, 1); check("t1_ndone", n_done, 1);
    check("t1_count", o_count, 1); check("t1_errs", {o_ee, o_el, o_em}, 3'b000);

    // 2: early tlast on row 0 column 2
    do_reset(); en = 1;
    send_lines(8'h30, 3, 4, 4, 3'b111, -1);
    expect_done("t2");
    tick();
    check("t2_nvld", n_vld, 11); check("t2_count", o_count, 1);
    check("t2_errs", {o_ee, o_el, o_em}, 3'b100);

    // 3: missing tlast on row 1
    do_reset(); en = 1;
    send_lines(8'h50, 4, 4, 4, 3'b101, -1);
    expect_done("t3");
    tick();
    check("t3_nvld", n_vld, 12); check("t3_errs", {o_ee, o_el, o_em}, 3'b010);

    // 4: tuser on beat 6 restarts the frame
    do_reset(); en = 1;
    for (int k = 1; k <= 17; k++)
      beat(8'h70 + DW'(k), (k == 1 || k == 6), (k == 4) || (k >= 6 && (k - 6) % 4 == 3), 0);
    expect_done("t4");
    tick();
    check("t4_nvld", n_vld, 17); check("t4_nsof", n_sof, 2); check("t4_ndone", n_done, 1);
    check("t4_count", o_count, 1); check("t4_errs", {o_ee, o_el, o_em}, 3'b001);

    // 5: enable dropped mid-frame; frame completes, then controller idles
    do_reset(); en = 1;
    for (int k = 0; k < 12; k++) begin
      if (k == 4) en = 0;
      beat(8'hC0 + DW'(k), (k == 0), (k % 4 == 3), 0);
    end
    expect_done("t5");
    tick();
    axis_if.tdata = 8'hEE; axis_if.tvalid = 1; axis_if.tuser = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_idle_tready", axis_if.tready, 0);
      check("t5_idle_busy",   o_busy,         0);
      tick();
    end
    axis_if.tvalid = 0; axis_if.tuser = 0;
    check("t5_nvld", n_vld, 12); check("t5_count", o_count, 1);

    // 6: random gaps over two frames, clear coinciding with an error set
    do_reset(); en = 1; g_gaps = 1;
    send_lines(8'h90, 4, 4, 2, 3'b111, 9);
    send_lines(8'hB0, 4, 4, 4, 3'b111, -1);
    g_gaps = 0;
    tick(); tick();
    check("t6_nvld", n_vld, 22); check("t6_count", o_count, 2);
    check("t6_early_held", o_ee, 1);
    clr = 1; tick(); clr = 0;
    @(negedge clk); check("t6_early_cleared", o_ee, 0);
    tick();

    // 7: reset mid-frame clears everything; next frame is clean
    do_reset(); en = 1;
    send_lines(8'h20, 4, 4, 4, 3'b111, -1);
    for (int k = 0; k < 5; k++) beat(8'h40 + DW'(k), (k == 0), (k == 3), 0);
    rst = 1; tick();
    check("t7_busy",   o_busy, 0); check("t7_tready", axis_if.tready, 0);
    check("t7_valid",  o_data_valid, 0); check("t7_count", o_count, 0);
    rst = 0; en = 1;
    n_vld = 0;
    send_lines(8'h60, 4, 4, 4, 3'b111, -1);
    expect_done("t7");
    tick();
    check("t7_nvld", n_vld, 12); check("t7_count_after", o_count, 1);
    check("t7_errs", {o_ee, o_el, o_em}, 3'b000);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/median_frame_ctrl.md
# median_frame_ctrl

Frame-sequencing controller at the input of the 3x3 median pipeline, between the upstream AXI4-Stream video source and the pixel receiver. Owns s_axis_tready, locks onto start-of-frame, counts columns and rows, validates line framing against the configured geometry, and forwards accepted pixels with a clean SOF strobe. Provides a one-cycle inter-frame gap, frame-done pulses, a frame counter, and sticky framing-error flags for software.

## Interface
- DATA_WIDTH, 8, pixel width
- IMG_WIDTH, 1280, pixels per line (≥2)
- IMG_HEIGHT, 1024, lines per frame (≥2)
- i_clk  in  1  clock; all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_enable  in  1  level; permits frame acceptance
- i_clear_err  in  1  pulse; clears sticky error flags
- s_axis_tdata  in  DATA_WIDTH  input pixel
- s_axis_tvalid  in  1  input beat valid
- s_axis_tuser  in  1  start of frame
- s_axis_tlast  in  1  end of line
- s_axis_tready  out  1  beat accepted when tvalid & tready
- o_data  out  DATA_WIDTH  forwarded pixel, to receiver
- o_data_valid  out  1  forwarded pixel valid
- o_start_of_frame  out  1  high with first forwarded pixel of a frame
- o_busy  out  1  high in ACTIVE
- o_frame_done  out  1  one-cycle pulse per completed frame
- o_frame_count  out  16  completed frames, wraps 0xFFFF→0
- o_err_early_eol  out  1  sticky: tlast before column IMG_WIDTH-1
- o_err_late_eol  out  1  sticky: no tlast at column IMG_WIDTH-1
- o_err_sof_mid  out  1  sticky: tuser inside an active frame

## Operation
- States: IDLE, WAIT_SOF, ACTIVE, DONE. Reset → IDLE.
- s_axis_tready = 1 in WAIT_SOF and ACTIVE, 0 in IDLE and DONE; decoded from the state register only, never from tvalid.
- IDLE: i_enable=1 → WAIT_SOF.
- WAIT_SOF: i_enable=0 → IDLE. Accepted beat with tuser=0 is dropped (not forwarded). Accepted beat with tuser=1 is forwarded with o_start_of_frame=1, col←1, row←0, → ACTIVE.
- ACTIVE: every accepted beat is forwarded. col counts 0..IMG_WIDTH-1, row counts 0..IMG_HEIGHT-1. Widths are $clog2(IMG_WIDTH) and $clog2(IMG_HEIGHT).
  - Beat at col=IMG_WIDTH-1: col←0, row←row+1. If tlast=0, set err_late_eol.
  - Beat at col<IMG_WIDTH-1 with tlast=1: set err_early_eol, col←0, row←row+1 (resync to line).
  - Beat with tuser=1: set err_sof_mid. Frame restarts with this beat: forwarded with o_start_of_frame=1, col←1, row←0. Aborted frame is not counted. tuser takes precedence over the tlast checks on the same beat.
  - Frame end: the beat that takes row past IMG_HEIGHT-1 (normal or early-eol wrap) → DONE.
  - i_enable is ignored in ACTIVE; the current frame always completes.
- DONE (exactly 1 cycle): o_frame_done=1, o_frame_count+1. Then → WAIT_SOF if i_enable=1, else IDLE.
- Error flags: set on the offending beat, held until i_clear_err. A set event and i_clear_err in the same cycle → the flag stays 1.
- tvalid gaps: counters and state hold; no forwarded output.
- Reset mid-frame: immediate return to IDLE, counters 0, and all outputs deassert on the next edge. Errors and frame count clear.

## Timing
- Reset values: s_axis_tready=0, o_data=0, o_data_valid=0, o_start_of_frame=0, o_busy=0, o_frame_done=0, o_frame_count=0, all error flags 0.
- Forwarding latency is 1 cycle: a beat accepted at edge N appears on o_data/o_data_valid/o_start_of_frame after edge N+1. o_data holds its value when o_data_valid=0.
- Error flags rise 1 cycle after the offending beat.
- Last beat accepted at edge N: state is DONE in cycle N+1 with tready=0 and o_frame_done=1. tready returns to 1 in cycle N+2 if i_enable=1.
- Minimum spacing between the last pixel of one frame and the SOF of the next is one bubble cycle.
- o_busy is registered and equals (state==ACTIVE).

## Test plan
Bench parameters: IMG_WIDTH=4, IMG_HEIGHT=3.
- Reset, i_enable=1, 3 beats with tuser=0, then a clean 12-beat frame → 3 junk beats dropped; 12 o_data_valid pulses; o_start_of_frame only on the first; o_frame_done 1 cycle after the 12th beat; frame_count=1; no error flags set.
- tlast on column 2 of row 0, rest clean → err_early_eol=1; the next beat counts as row1 col0; frame_done after the 11th beat; frame_count=1.
- tlast missing on row 1 → err_late_eol=1; frame_done after the 12th beat.
- tuser on beat 6 → err_sof_mid=1; o_start_of_frame on beats 1 and 6; frame_done after 11 more beats (17 total); frame_count=1.
- i_enable dropped on beat 5 → frame completes; state goes DONE→IDLE; tready=0; a following tuser beat is not accepted; o_busy=0.
- Random tvalid gaps over 2 frames, plus i_clear_err asserted in the same cycle an error sets → outputs match gap-free order; frame_count=2; the flag stays 1; a later i_clear_err alone → 0.
